// File: rtl/hqm_rcfwl_gclk_pccdu_dop_seq_pkg.sv
// Shared types and defaults for the pccdu DOP sequencer.
package hqm_rcfwl_gclk_pccdu_dop_seq_pkg;

  typedef enum logic [1:0] {INIT, SYNC, RUN, REALIGN} dop_seq_state_t;

  // 36 = LCM(1,2,3,4,9,12), so every supported divisor lines up on each sync.
  localparam int DEFAULT_SYNC_PERIOD = 36;

endpackage

// File: rtl/hqm_rcfwl_gclk_pccdu_dop_seq_settle.sv
// Per-DOP settle counter and ack flop: the ack follows the applied enable
// SETTLE_CYC cycles after a sync boundary that changed (or re-hit) it.
module hqm_rcfwl_gclk_pccdu_dop_seq_settle
  import hqm_rcfwl_gclk_pccdu_dop_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic boundary_i,
  input  logic change_i,
  input  logic en_i,
  output logic ack_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ack_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ack_q <= ack_d;
    end
  end

  // A boundary during a running settle restarts it; the ack holds until completion.
  always_comb begin
    cnt_d = cnt_q;
    ack_d = ack_q;
    if (boundary_i && (change_i || (cnt_q != 4'd0))) begin
      cnt_d = 4'(SETTLE_CYC);
    end else if (cnt_q == 4'd1) begin
      cnt_d = 4'd0;
      ack_d = en_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  assign ack_o = ack_q;

endmodule

// File: rtl/hqm_rcfwl_gclk_pccdu_dop_seq.sv
// Sequencer for a bank of pccdu DOP drivers: common divider-sync pulse,
// boundary-aligned clock-enable scheduling and req/ack handshake.
module hqm_rcfwl_gclk_pccdu_dop_seq
  import hqm_rcfwl_gclk_pccdu_dop_seq_pkg::*;
#(
  parameter int NUM_DOP     = 4,
  parameter int SYNC_PERIOD = DEFAULT_SYNC_PERIOD,
  parameter int INIT_CYC    = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int CNT_W       = $clog2(SYNC_PERIOD)
) (
  input  logic               fdop_preclk_grid,
  input  logic               fdop_rst,
  input  logic               fsync_ext_req,
  input  logic [NUM_DOP-1:0] fdop_clken_req,
  input  logic               fscan_clken_ovr,
  output logic               adop_div_sync,
  output logic [NUM_DOP-1:0] adop_clken,
  output logic [NUM_DOP-1:0] adop_clken_ack,
  output logic               adop_sync_locked,
  output logic [CNT_W-1:0]   adop_phase
);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(SYNC_PERIOD - 1);
  localparam logic [7:0]       INIT_LAST  = 8'(INIT_CYC - 1);

  dop_seq_state_t     state_q, state_d;
  logic [7:0]         init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic               locked_q, locked_d;
  logic               div_sync;
  logic               at_last;
  logic [NUM_DOP-1:0] en_q, en_d, en_change;

  assign at_last = (phase_q == PHASE_LAST);

  always_ff @(posedge fdop_preclk_grid or posedge fdop_rst) begin
    if (fdop_rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      phase_q    <= '0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      en_q       <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
      locked_q   <= locked_d;
      en_q       <= en_d;
    end
  end

  // Requests landing on a pulse cycle or on the wrap-deciding cycle are absorbed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_cnt_q == INIT_LAST) state_d = SYNC;
      SYNC:    state_d = RUN;
      RUN:     if (fsync_ext_req && !wrap_q && !at_last) state_d = REALIGN;
      REALIGN: state_d = SYNC;
      default: state_d = INIT;
    endcase
  end

  // Phase reads 0 on every pulse cycle, so pulses are exactly SYNC_PERIOD apart.
  always_comb begin
    init_cnt_d = init_cnt_q;
    phase_d    = phase_q;
    wrap_d     = 1'b0;
    locked_d   = locked_q;
    div_sync   = wrap_q;
    case (state_q)
      INIT: begin
        init_cnt_d = (init_cnt_q == INIT_LAST) ? 8'd0 : init_cnt_q + 8'd1;
      end
      SYNC: begin
        div_sync = 1'b1;
        locked_d = 1'b1;
        phase_d  = CNT_W'(1);
      end
      RUN: begin
        if (at_last) begin
          phase_d = '0;
          wrap_d  = 1'b1;
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      REALIGN: begin
        phase_d = '0;
      end
      default: ;
    endcase
  end

  assign en_change = fdop_clken_req ^ en_q;
  assign en_d      = div_sync ? fdop_clken_req : en_q;

  for (genvar g = 0; g < NUM_DOP; g++) begin : g_settle
    hqm_rcfwl_gclk_pccdu_dop_seq_settle #(
      .SETTLE_CYC (SETTLE_CYC)
    ) u_settle (
      .clk_i      (fdop_preclk_grid),
      .rst_i      (fdop_rst),
      .boundary_i (div_sync),
      .change_i   (en_change[g]),
      .en_i       (en_q[g]),
      .ack_o      (adop_clken_ack[g])
    );
  end

  assign adop_div_sync    = div_sync;
  assign adop_clken       = en_q | {NUM_DOP{fscan_clken_ovr}};
  assign adop_sync_locked = locked_q;
  assign adop_phase       = locked_q ? phase_q : '0;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pccdu_dop_seq.sv
// Self-checking bench for the DOP sequencer: directed scenarios plus random
// traffic compared against a timeline model of pulses, enables and acks.
module tb_hqm_rcfwl_gclk_pccdu_dop_seq;

  localparam int NUM_DOP     = 4;
  localparam int SYNC_PERIOD = 36;
  localparam int INIT_CYC    = 8;
  localparam int SETTLE_CYC  = 2;
  localparam int CNT_W       = 6;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               extReq = 1'b0;
  logic [NUM_DOP-1:0] clkenReq = '0;
  logic               scanOvr = 1'b0;
  logic               divSync;
  logic [NUM_DOP-1:0] clken;
  logic [NUM_DOP-1:0] clkenAck;
  logic               syncLocked;
  logic [CNT_W-1:0]   phase;

  int checks = 0;
  int errors = 0;

  // Reference timeline: cycle index since reset release, last pulse cycle,
  // pending realign pulse cycle, applied enables and per-DOP ack deadlines.
  int               t;
  int               lastP;
  int               target;
  logic [NUM_DOP-1:0] enM;
  logic [NUM_DOP-1:0] ackM;
  int               dl [NUM_DOP];
  bit               pNow;
  bit               lockM;
  int               phM;

  hqm_rcfwl_gclk_pccdu_dop_seq #(
    .NUM_DOP     (NUM_DOP),
    .SYNC_PERIOD (SYNC_PERIOD),
    .INIT_CYC    (INIT_CYC),
    .SETTLE_CYC  (SETTLE_CYC)
  ) dut (
    .fdop_preclk_grid (clock),
    .fdop_rst         (reset),
    .fsync_ext_req    (extReq),
    .fdop_clken_req   (clkenReq),
    .fscan_clken_ovr  (scanOvr),
    .adop_div_sync    (divSync),
    .adop_clken       (clken),
    .adop_clken_ack   (clkenAck),
    .adop_sync_locked (syncLocked),
    .adop_phase       (phase)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic modelReset();
    t      = 0;
    lastP  = -1;
    target = -1;
    enM    = '0;
    ackM   = '0;
    for (int i = 0; i < NUM_DOP; i++) dl[i] = -1;
  endtask

  // Expected pulse/lock/phase for the current cycle, before its inputs matter.
  task automatic predict();
    pNow  = (t == INIT_CYC) || (target >= 0 && t == target) ||
            (lastP >= 0 && (t - lastP) == SYNC_PERIOD);
    lockM = (t > INIT_CYC);
    phM   = pNow ? 0 : (lockM ? (t - lastP) : 0);
  endtask

  // Called #1 after a rising edge with the cycle's inputs already driven.
  task automatic applyStimulus();
    predict();
    @(negedge clock);
    if (pNow) begin
      lastP = t;
      if (t == target) target = -1;
    end
    for (int i = 0; i < NUM_DOP; i++) if (dl[i] == t) ackM[i] = enM[i];
    checkOutput("div_sync", 32'(divSync), 32'(pNow));
    checkOutput("clken", 32'(clken), 32'(enM | {NUM_DOP{scanOvr}}));
    checkOutput("ack", 32'(clkenAck), 32'(ackM));
    checkOutput("locked", 32'(syncLocked), 32'(lockM));
    checkOutput("phase", 32'(phase), 32'(phM));
    if (extReq && lockM && !pNow && target < 0 && (t - lastP) != SYNC_PERIOD - 1)
      target = t + 2;
    if (pNow) begin
      for (int i = 0; i < NUM_DOP; i++)
        if (clkenReq[i] != enM[i] || t < dl[i]) dl[i] = t + SETTLE_CYC + 1;
      enM = clkenReq;
    end
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  // Run idle cycles until the model says the coming cycle has the given phase.
  task automatic waitPhase(input int ph);
    int k;
    k = 0;
    predict();
    while (!(lockM && phM == ph) && k < 200) begin
      applyStimulus();
      predict();
      k++;
    end
    if (k >= 200) checkOutput("phase_wait_timeout", 32'(k), 32'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_div_sync"}, 32'(divSync), 32'd0);
    checkOutput({tag, "_clken"}, 32'(clken), 32'd0);
    checkOutput({tag, "_ack"}, 32'(clkenAck), 32'd0);
    checkOutput({tag, "_locked"}, 32'(syncLocked), 32'd0);
    checkOutput({tag, "_phase"}, 32'(phase), 32'd0);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    extReq   = 1'b0;
    scanOvr  = 1'b0;
    #1;
    checkResetOutputs("reset");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    modelReset();
    #2;
    doReset();

    // Free-running pulses with no requests.
    idleCycles(100);

    // Enable request raised mid-period waits for the next boundary.
    waitPhase(10);
    clkenReq = 4'b0101;
    idleCycles(40);

    // External realign in mid-period.
    waitPhase(20);
    extReq = 1'b1;
    applyStimulus();
    extReq = 1'b0;
    idleCycles(80);

    // External realign coinciding with the wrap-deciding cycle.
    waitPhase(SYNC_PERIOD - 1);
    extReq = 1'b1;
    applyStimulus();
    extReq = 1'b0;
    idleCycles(80);

    // Scan override with all requests off.
    clkenReq = '0;
    idleCycles(45);
    scanOvr = 1'b1;
    idleCycles(5);
    scanOvr = 1'b0;
    idleCycles(5);

    // Reset mid-run with every ack set.
    clkenReq = 4'b1111;
    idleCycles(45);
    checkOutput("ack_all_on", 32'(clkenAck), 32'hf);
    reset = 1'b1;
    #1;
    checkResetOutputs("midrun");
    @(posedge clock);
    #1;
    doReset();
    idleCycles(50);

    // Random traffic.
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 49) == 0) clkenReq = NUM_DOP'($urandom);
      extReq = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) scanOvr = ~scanOvr;
      applyStimulus();
    end
    extReq  = 1'b0;
    scanOvr = 1'b0;
    idleCycles(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
